// File: rtl/router_local_port_if.sv
// Local-port signal bundle: ddma-facing flit link plus switch-facing framed flit link.
interface router_local_port_if #(
  parameter int FLIT_WIDTH = 32
);
  // ddma side
  logic                  rx;
  logic [FLIT_WIDTH-1:0] data_i;
  logic                  credit_o;
  logic                  tx;
  logic [FLIT_WIDTH-1:0] data_o;
  logic                  credit_i;
  // switch side, inbound
  logic                  in_req;
  logic [FLIT_WIDTH-1:0] in_dest;
  logic                  in_grant;
  logic                  in_valid;
  logic [FLIT_WIDTH-1:0] in_data;
  logic                  in_eop;
  logic                  in_ready;
  // switch side, outbound
  logic                  out_valid;
  logic [FLIT_WIDTH-1:0] out_data;
  logic                  out_ready;

  // Router end of the link
  modport slave (
    input  rx, data_i, credit_i, in_grant, in_ready, out_valid, out_data,
    output credit_o, tx, data_o, in_req, in_dest, in_valid, in_data, in_eop, out_ready
  );

  // ddma / switch environment end of the link
  modport master (
    output rx, data_i, credit_i, in_grant, in_ready, out_valid, out_data,
    input  credit_o, tx, data_o, in_req, in_dest, in_valid, in_data, in_eop, out_ready
  );
endinterface

// File: rtl/router_local_port.sv
// Router-side local port: inbound credit-flow-controlled FIFO with header/size/payload
// framing toward the switch, and a one-entry outbound register stage toward the ddma.
module router_local_port #(
  parameter int FLIT_WIDTH   = 32,
  parameter int BUFFER_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  router_local_port_if.slave    lp,
  output logic                  err_ovf
);

  localparam int PW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int CW = $clog2(BUFFER_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(BUFFER_DEPTH);

  typedef enum logic [1:0] {IN_HEADER, IN_SIZE, IN_PAYLOAD} in_state_t;

  logic [FLIT_WIDTH-1:0] mem [BUFFER_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  empty, full, push, pop, take;
  logic [FLIT_WIDTH-1:0] head;
  logic [FLIT_WIDTH-1:0] remaining;
  in_state_t             state;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);
  assign head  = mem[rd_ptr];

  // Inbound framing outputs and FIFO handshake decode
  always_comb begin
    lp.in_req   = 1'b0;
    lp.in_valid = 1'b0;
    lp.in_eop   = 1'b0;
    unique case (state)
      IN_HEADER:  lp.in_req = ~empty;
      IN_SIZE: begin
        lp.in_valid = ~empty;
        lp.in_eop   = ~empty && (head == '0);
      end
      IN_PAYLOAD: begin
        lp.in_valid = ~empty;
        lp.in_eop   = ~empty && (remaining == FLIT_WIDTH'(1));
      end
      default: ;
    endcase
  end

  assign lp.in_dest  = head;
  assign lp.in_data  = head;
  assign take        = lp.in_valid & lp.in_ready;
  assign pop         = (lp.in_req & lp.in_grant) | take;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a flit then.
  assign push        = lp.rx & (~full | pop);
  // Two free slots: one for the flit the ddma may already be launching this cycle.
  assign lp.credit_o = (DEPTH_C - count) >= CW'(2);
  assign lp.out_ready = ~lp.tx | lp.credit_i;

  // FIFO storage (data only, no reset needed)
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= lp.data_i;
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_ovf <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (lp.rx && !push) err_ovf <= 1'b1;
    end
  end

  // Framing FSM: header -> size -> payload flits, tracking payload flits left
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IN_HEADER;
      remaining <= '0;
    end else begin
      unique case (state)
        IN_HEADER: if (lp.in_req && lp.in_grant) state <= IN_SIZE;
        IN_SIZE: if (take) begin
          remaining <= head;
          state     <= (head == '0) ? IN_HEADER : IN_PAYLOAD;
        end
        IN_PAYLOAD: if (take) begin
          remaining <= remaining - FLIT_WIDTH'(1);
          if (remaining == FLIT_WIDTH'(1)) state <= IN_HEADER;
        end
        default: state <= IN_HEADER;
      endcase
    end
  end

  // Outbound register stage: load on accepted switch flit, clear on ddma credit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lp.tx     <= 1'b0;
      lp.data_o <= '0;
    end else if (lp.out_valid && lp.out_ready) begin
      lp.tx     <= 1'b1;
      lp.data_o <= lp.out_data;
    end else if (lp.tx && lp.credit_i) begin
      lp.tx     <= 1'b0;
    end
  end

endmodule
